// File: rtl/light_package.sv
// light_package: shared light colours and sensor lane indices
package light_package;
  typedef enum logic [1:0] {RED = 2'd0, YELLOW = 2'd1, GREEN = 2'd2} colors;
  localparam int LANE_ES = 0;
  localparam int LANE_WS = 1;
  localparam int LANE_EL = 2;
  localparam int LANE_WL = 3;
  localparam int LANE_NS = 4;
  localparam int NUM_LANES = 5;
endpackage

// File: rtl/traffic_sensor_conditioner_lane.sv
// sensor_lane: sync, debounce, demand latch and stuck-high detection for one loop detector
module sensor_lane #(
  parameter int DEB_CYCLES = 4,
  parameter int STUCK_CYCLES = 200
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  input  logic is_green,
  output logic sensor,
  output logic fault
);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int SW = $clog2(STUCK_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [SW-1:0] STUCK_MAX = SW'(STUCK_CYCLES);
  logic s1, s2, deb, req;
  logic [DW-1:0] deb_cnt;
  logic [SW-1:0] stuck_cnt;
  // two-flop synchroniser, then accept a new level only after DEB_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      deb <= 1'b0;
      deb_cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == deb) deb_cnt <= '0;
      else if (deb_cnt == DEB_LAST) begin
        deb <= s2;
        deb_cnt <= '0;
      end else deb_cnt <= deb_cnt + 1'b1;
    end
  end
  // latch demand until the lane is served; green clears even if demand is present
  always_ff @(posedge clk) begin
    if (!reset_n) req <= 1'b0;
    else if (is_green) req <= 1'b0;
    else if (deb) req <= 1'b1;
  end
  // count continuous debounced-high time; release clears the fault at once
  always_ff @(posedge clk) begin
    if (!reset_n || !deb) begin
      stuck_cnt <= '0;
      fault <= 1'b0;
    end else if (stuck_cnt != STUCK_MAX) begin
      stuck_cnt <= stuck_cnt + 1'b1;
      fault <= stuck_cnt == STUCK_MAX - 1'b1;
    end
  end
  assign sensor = fault ? req : deb | req;
endmodule

// File: rtl/traffic_sensor_conditioner.sv
// traffic_sensor_conditioner: turns five raw loop detectors into controller demand inputs
module traffic_sensor_conditioner
  import light_package::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int STUCK_CYCLES = 200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] raw_det,
  input  logic [1:0] e_str_light,
  input  logic [1:0] w_str_light,
  input  logic [1:0] e_left_light,
  input  logic [1:0] w_left_light,
  input  logic [1:0] ns_light,
  output logic       e_str_sensor,
  output logic       w_str_sensor,
  output logic       e_left_sensor,
  output logic       w_left_sensor,
  output logic       ns_sensor,
  output logic [4:0] fault
);
  logic [NUM_LANES-1:0][1:0] light;
  logic [NUM_LANES-1:0] sensor;
  assign light = {ns_light, w_left_light, e_left_light, w_str_light, e_str_light};
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    sensor_lane #(.DEB_CYCLES(DEB_CYCLES), .STUCK_CYCLES(STUCK_CYCLES)) u_lane (
      .clk(clk),
      .reset_n(reset_n),
      .raw(raw_det[i]),
      .is_green(light[i] == GREEN),
      .sensor(sensor[i]),
      .fault(fault[i])
    );
  end
  assign e_str_sensor = sensor[LANE_ES];
  assign w_str_sensor = sensor[LANE_WS];
  assign e_left_sensor = sensor[LANE_EL];
  assign w_left_sensor = sensor[LANE_WL];
  assign ns_sensor = sensor[LANE_NS];
endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// tb_traffic_sensor_conditioner: randomized + directed scoreboard bench against a behavioural lane model
module tb_traffic_sensor_conditioner;
  localparam int DEB = 3;
  localparam int STUCK = 20;
  localparam bit [1:0] C_RED = 2'd0, C_YEL = 2'd1, C_GRN = 2'd2, C_BAD = 2'd3;
  logic clk = 1'b0;
  logic reset_n;
  logic [4:0] raw_det;
  logic [1:0] e_str_light, w_str_light, e_left_light, w_left_light, ns_light;
  logic e_str_sensor, w_str_sensor, e_left_sensor, w_left_sensor, ns_sensor;
  logic [4:0] fault;
  traffic_sensor_conditioner #(.DEB_CYCLES(DEB), .STUCK_CYCLES(STUCK)) dut (
    .clk(clk), .reset_n(reset_n), .raw_det(raw_det),
    .e_str_light(e_str_light), .w_str_light(w_str_light), .e_left_light(e_left_light),
    .w_left_light(w_left_light), .ns_light(ns_light),
    .e_str_sensor(e_str_sensor), .w_str_sensor(w_str_sensor), .e_left_sensor(e_left_sensor),
    .w_left_sensor(w_left_sensor), .ns_sensor(ns_sensor), .fault(fault)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  bit [9:0] exp_q[$];
  bit v_rst;
  bit [4:0] v_raw;
  bit [1:0] v_light[5];
  // reference model state: detector samples still in flight, samples seen since the last level change
  bit m_pipe[5][$];
  bit m_since[5][$];
  bit m_deb[5];
  bit m_req[5];
  int m_rise[5];
  int edge_n = 0;
  task automatic model_edge(output bit [9:0] e);
    edge_n++;
    for (int l = 0; l < 5; l++) begin
      bit old_deb, smp, flip, flt, grn;
      old_deb = m_deb[l];
      grn = v_light[l] == C_GRN;
      if (!v_rst) begin
        m_pipe[l] = '{1'b0, 1'b0};
        m_since[l] = {};
        m_deb[l] = 1'b0;
        m_req[l] = 1'b0;
        flt = 1'b0;
      end else begin
        smp = m_pipe[l].pop_front();
        m_pipe[l].push_back(v_raw[l]);
        m_since[l].push_back(smp);
        flip = m_since[l].size() >= DEB;
        for (int k = 0; k < DEB; k++)
          if (flip && m_since[l][m_since[l].size() - 1 - k] == old_deb) flip = 1'b0;
        if (flip) begin
          m_deb[l] = !old_deb;
          m_since[l] = {};
          if (m_deb[l]) m_rise[l] = edge_n;
        end
        flt = old_deb && (edge_n - m_rise[l] >= STUCK);
        m_req[l] = grn ? 1'b0 : (old_deb ? 1'b1 : m_req[l]);
      end
      e[5 + l] = flt;
      e[l] = flt ? m_req[l] : (m_deb[l] | m_req[l]);
    end
  endtask
  task automatic tick();
    bit [9:0] e;
    @(negedge clk);
    reset_n = v_rst;
    raw_det = v_raw;
    e_str_light = v_light[0];
    w_str_light = v_light[1];
    e_left_light = v_light[2];
    w_left_light = v_light[3];
    ns_light = v_light[4];
    model_edge(e);
    exp_q.push_back(e);
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic all_lights(input bit [1:0] c);
    for (int l = 0; l < 5; l++) v_light[l] = c;
  endtask
  // monitor: compare each post-edge output with the oldest expectation
  always @(posedge clk) begin
    bit [9:0] e;
    bit [9:0] got;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = {fault, ns_sensor, w_left_sensor, e_left_sensor, w_str_sensor, e_str_sensor};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL outputs t=%0t {fault,sensors} got %b expected %b", $time, got, e);
      end
    end
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    int hold[5];
    int lhold[5];
    all_lights(C_RED);
    v_raw = 5'h1F;
    v_rst = 1'b0;
    for (int l = 0; l < 5; l++) m_pipe[l] = '{1'b0, 1'b0};
    ticks(3);
    v_rst = 1'b1;
    ticks(10);
    v_rst = 1'b0; v_raw = 5'h00;
    ticks(2);
    v_rst = 1'b1;
    v_raw[4] = 1'b1; ticks(2);
    v_raw[4] = 1'b0; ticks(8);
    v_raw[4] = 1'b1; ticks(4);
    v_raw[4] = 1'b0; ticks(8);
    v_rst = 1'b0; ticks(2); v_rst = 1'b1;
    v_raw[0] = 1'b1; ticks(6);
    v_raw[0] = 1'b0; ticks(12);
    v_light[0] = C_GRN; ticks(1);
    v_light[0] = C_RED; ticks(4);
    v_light[3] = C_GRN;
    for (int i = 0; i < 48; i++) begin
      v_raw[3] = (i % 8) < 4;
      tick();
    end
    v_raw[3] = 1'b0; ticks(6);
    v_light[3] = C_RED; ticks(2);
    v_raw[2] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      v_light[2] = ((i / 4) % 2) ? C_GRN : C_RED;
      tick();
    end
    v_light[2] = C_RED;
    v_raw[2] = 1'b0; ticks(10);
    v_rst = 1'b0; ticks(1); v_rst = 1'b1;
    v_raw = 5'h1F; ticks(4);
    all_lights(C_GRN); ticks(6);
    v_raw = 5'h00; ticks(8);
    all_lights(C_YEL); v_light[1] = C_BAD; ticks(2);
    v_raw = 5'h0A; ticks(8);
    v_raw = 5'h00; ticks(8);
    for (int l = 0; l < 5; l++) begin hold[l] = 0; lhold[l] = 0; end
    for (int c = 0; c < 3000; c++) begin
      for (int l = 0; l < 5; l++) begin
        if (hold[l] == 0) begin
          v_raw[l] = $urandom_range(0, 1);
          hold[l] = ($urandom_range(0, 3) == 0) ? $urandom_range(25, 45) : $urandom_range(1, 6);
        end else hold[l]--;
        if (lhold[l] == 0) begin
          v_light[l] = 2'($urandom_range(0, 3));
          lhold[l] = $urandom_range(1, 15);
        end else lhold[l]--;
      end
      v_rst = $urandom_range(0, 299) != 0;
      tick();
    end
    v_rst = 1'b1;
    ticks(2);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
